auth_server: RTL and testbench
==============================

// Module: auth_server
// PURPOSE
//  Server stage downstream of the user RAM. Takes a start/frame request, checks the frame ID
//  against a programmable table of authorised IDs, and transforms the data byte with a per-ID key.
//  Answers each request with one auth_done or auth_fail pulse; each result byte returns via wb_data/wb_valid.
//  Results leave in auth_done order, which is the order the RAM's write-back queue expects.
// PARAMETERS
//  N_IDS       8  authorised-ID table entries; IDX_W = clog2(N_IDS)
//  PROC_LAT    3  processing cycles from end of lookup to DONE (>=1)
//  FIFO_DEPTH  4  write-back FIFO entries (power of two)
//  GUARD_CYC   2  cycles start is ignored after a done/fail pulse (lets the requester re-arm)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      request valid; frame stable while high
//  frame      in   16     [15]=already-processed, [14:8]=ID, [7:0]=data
//  auth_done  out  1      1-cycle pulse: request accepted, result queued
//  auth_fail  out  1      1-cycle pulse: request rejected, nothing queued
//  wb_data    out  8      result byte (data ^ key), valid with wb_valid
//  wb_valid   out  1      1-cycle pulse per result
//  wb_hold    in   1      pop inhibit; tie to the RAM load strobe so no write-back is lost
//  cfg_we     in   1      table write strobe
//  cfg_idx    in   IDX_W  table entry index
//  cfg_vld    in   1      entry valid bit to write
//  cfg_id     in   7      entry ID
//  cfg_key    in   8      entry XOR key
//  busy       out  1      FSM not in IDLE
//  fail_cnt   out  8      saturating count of auth_fail pulses
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, table valid bits cleared, FIFO emptied, fail_cnt=0.
//  Reset mid-request aborts it; no pulse is emitted.
//  FSM states: IDLE, CHECK, PROC, DONE, FAIL, GUARD.
//   IDLE : start=1 at edge T -> latch frame, go to CHECK.
//   CHECK: one cycle of lookup on registered table contents.
//          Match = lowest index with vld && id==frame[14:8].
//          frame[15]=1 or no match -> FAIL; else -> PROC, cnt=PROC_LAT-1, latch key.
//   PROC : cnt!=0 -> decrement. cnt==0 and FIFO not full -> push frame[7:0]^key, go to DONE.
//          cnt==0 and FIFO full -> stay in PROC (stall), no pulse.
//   DONE : auth_done=1 for exactly 1 cycle -> GUARD.
//   FAIL : auth_fail=1 for exactly 1 cycle, fail_cnt += 1 (holds at 255) -> GUARD.
//   GUARD: start ignored for GUARD_CYC cycles -> IDLE.
//  auth_done/auth_fail decode directly from the state register (glitch-free, never both high).
//  Latency, start sampled at edge T, no stall:
//   auth_fail sampled high at edge T+2.
//   auth_done sampled high at edge T+PROC_LAT+2.
//  Table write in the same cycle as CHECK: the lookup uses the pre-write contents.
//  Write-back FIFO:
//   - Pop when !empty && !wb_hold; wb_valid/wb_data registered, so earliest wb_valid is the
//     cycle after auth_done.
//   - wb_valid low whenever no pop; wb_data holds its last value.
//   - Push and pop in the same cycle allowed; count unchanged; pointers wrap modulo FIFO_DEPTH.
//   - Push never occurs while full (FSM stall guarantees it).
//   - wb_hold asserted indefinitely: FIFO fills, FSM stalls in PROC, start is not sampled.
//  All arithmetic is modulo field width except fail_cnt, which saturates.
// STRUCTURE
//  Shared package auth_pkg:
//   - frame field positions (FR_PROC_BIT=15, FR_ID_MSB=14, FR_ID_LSB=8, FR_DATA_MSB=7)
//   - FSM state encoding localparams
//   - ID_W=7, DATA_W=8
//  Sub-module wb_fifo (sync FIFO; params W, DEPTH; push/pop/full/empty/count).
//  Table registers and FSM stay in auth_server.
// TESTING
//  1 cfg idx0={vld,ID=0x15,key=0xFF}; start, frame=0x1534 -> auth_done at T+5, wb_data=0xCB
//    one cycle later.
//  2 frame=0x1634 (ID 0x16 absent) -> auth_fail at T+2, no wb_valid, fail_cnt=1.
//  3 frame=0x9534 (bit15 set, ID valid) -> auth_fail, no push.
//  4 wb_hold=1, 5 valid requests back to back -> 4 auth_done, 5th stalls in PROC.
//    Release hold -> 5 wb_valid pulses in order, 5th auth_done follows.
//  5 start held high through done and GUARD -> next request accepted only after GUARD_CYC
//    cycles; 2 requests give 2 pulses.
//  6 rst_n low while in PROC -> next cycle busy=0, FIFO empty, no pulses; 256 fails -> fail_cnt=255.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared definitions for the authorisation server: frame layout, widths and FSM encoding.
package auth_pkg;

  localparam int ID_W    = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;

  localparam int FR_PROC_BIT = 15;
  localparam int FR_ID_MSB   = 14;
  localparam int FR_ID_LSB   = 8;
  localparam int FR_DATA_MSB = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_PROC  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;
  localparam logic [2:0] ST_GUARD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_PROC  = ST_PROC,
    S_DONE  = ST_DONE,
    S_FAIL  = ST_FAIL,
    S_GUARD = ST_GUARD
  } state_t;

  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] data,
                                              input logic [DATA_W-1:0] key);
    return data ^ key;
  endfunction

endpackage

// File: rtl/auth_server_wb_fifo.sv
// Synchronous write-back FIFO; read data is the head entry, pointers wrap on a power-of-two depth.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/auth_server.sv
// Authorisation server: looks a frame ID up in a programmable table, XORs the data byte with
// the matching key and queues the result for write-back in completion order.
module auth_server
  import auth_pkg::*;
#(
  parameter int N_IDS      = 8,
  parameter int PROC_LAT   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // start is a level request: hold it with frame stable until busy rises; results leave as
  // single-cycle wb_valid pulses, and wb_hold high blocks the pop for that cycle.
  input  logic                          start,
  input  logic [FRAME_W-1:0]            frame,
  output logic                          auth_done,
  output logic                          auth_fail,
  output logic [DATA_W-1:0]             wb_data,
  output logic                          wb_valid,
  input  logic                          wb_hold,
  input  logic                          cfg_we,
  input  logic [$clog2(N_IDS)-1:0]      cfg_idx,
  input  logic                          cfg_vld,
  input  logic [ID_W-1:0]               cfg_id,
  input  logic [DATA_W-1:0]             cfg_key,
  output logic                          busy,
  output logic [7:0]                    fail_cnt,
  output state_t                        dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_cnt
);

  localparam int CNT_W  = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
  localparam int GCNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  logic [N_IDS-1:0]   tbl_vld;
  logic [ID_W-1:0]    tbl_id  [N_IDS];
  logic [DATA_W-1:0]  tbl_key [N_IDS];

  state_t             state;
  logic [FRAME_W-1:0] fr_q;
  logic [DATA_W-1:0]  key_q;
  logic [CNT_W-1:0]   cnt;
  logic [GCNT_W-1:0]  gcnt;
  logic [7:0]         fail_q;

  logic               hit;
  logic [DATA_W-1:0]  hit_key;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_vld <= '0;
    end else if (cfg_we && (int'(cfg_idx) < N_IDS)) begin
      tbl_vld[cfg_idx] <= cfg_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && (int'(cfg_idx) < N_IDS)) begin
      tbl_id[cfg_idx]  <= cfg_id;
      tbl_key[cfg_idx] <= cfg_key;
    end
  end

  // Scan high to low so the lowest matching index wins; registered contents only, so a
  // write landing on the CHECK edge is not seen by that lookup.
  always_comb begin
    hit     = 1'b0;
    hit_key = '0;
    for (int i = N_IDS - 1; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_id[i] == fr_q[FR_ID_MSB:FR_ID_LSB])) begin
        hit     = 1'b1;
        hit_key = tbl_key[i];
      end
    end
  end

  assign fifo_push = (state == S_PROC) && (cnt == '0) && !fifo_full;
  assign fifo_pop  = !fifo_empty && !wb_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      fr_q   <= '0;
      key_q  <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      fail_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            fr_q  <= frame;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (fr_q[FR_PROC_BIT] || !hit) begin
            state <= S_FAIL;
          end else begin
            state <= S_PROC;
            cnt   <= CNT_W'(PROC_LAT - 1);
            key_q <= hit_key;
          end
        end
        S_PROC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!fifo_full) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_GUARD;
          gcnt  <= GCNT_W'(GUARD_CYC - 1);
        end
        S_FAIL: begin
          if (fail_q != 8'hFF) fail_q <= fail_q + 8'd1;
          state <= S_GUARD;
          gcnt  <= GCNT_W'(GUARD_CYC - 1);
        end
        S_GUARD: begin
          if (gcnt == '0) state <= S_IDLE;
          else            gcnt  <= gcnt - GCNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_valid <= fifo_pop;
      if (fifo_pop) wb_data <= fifo_dout;
    end
  end

  wb_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (xform(fr_q[FR_DATA_MSB:0], key_q)),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_fifo_cnt)
  );

  assign auth_done = (state == S_DONE);
  assign auth_fail = (state == S_FAIL);
  assign busy      = (state != S_IDLE);
  assign fail_cnt  = fail_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_auth_server.sv
// Bench for auth_server: reference table model, expected-result queues and a pulse monitor.
module tb_auth_server;
  import auth_pkg::*;

  localparam int N_IDS      = 8;
  localparam int PROC_LAT   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int GUARD_CYC  = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] frame;
  logic        auth_done;
  logic        auth_fail;
  logic [7:0]  wb_data;
  logic        wb_valid;
  logic        wb_hold;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_vld;
  logic [6:0]  cfg_id;
  logic [7:0]  cfg_key;
  logic        busy;
  logic [7:0]  fail_cnt;
  state_t      dbg_state;
  logic [2:0]  dbg_fifo_cnt;

  auth_server #(
    .N_IDS(N_IDS), .PROC_LAT(PROC_LAT), .FIFO_DEPTH(FIFO_DEPTH), .GUARD_CYC(GUARD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame(frame),
    .auth_done(auth_done), .auth_fail(auth_fail), .wb_data(wb_data), .wb_valid(wb_valid),
    .wb_hold(wb_hold), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_vld(cfg_vld),
    .cfg_id(cfg_id), .cfg_key(cfg_key), .busy(busy), .fail_cnt(fail_cnt),
    .dbg_state(dbg_state), .dbg_fifo_cnt(dbg_fifo_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // reference model and scoreboard
  bit          m_vld [N_IDS];
  logic [6:0]  m_id  [N_IDS];
  logic [7:0]  m_key [N_IDS];
  int          m_fail;
  logic [0:0]  exp_res_q [$];
  logic [7:0]  exp_wb_q  [$];
  int          n_checks;
  int          n_fail;
  int          n_wb_seen;
  int          n_pulse_seen;
  bit          rnd_hold;
  bit          pw_en;
  logic [2:0]  pw_idx;
  logic [6:0]  pw_id;
  logic [7:0]  pw_key;
  logic [0:0]  e_res;
  logic [7:0]  e_wb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_IDS; i++) begin
      m_vld[i] = 1'b0;
      m_id[i]  = '0;
      m_key[i] = '0;
    end
    m_fail = 0;
  endtask

  function automatic void model_eval(input logic [15:0] fr, output bit ok, output logic [7:0] res);
    ok  = 1'b0;
    res = '0;
    if (!fr[15]) begin
      for (int i = 0; i < N_IDS; i++) begin
        if (m_vld[i] && m_id[i] == fr[14:8]) begin
          ok  = 1'b1;
          res = fr[7:0] ^ m_key[i];
          break;
        end
      end
    end
  endfunction

  task automatic expect_req(input logic [15:0] fr, output bit ok);
    logic [7:0] res;
    model_eval(fr, ok, res);
    exp_res_q.push_back(1'(ok));
    if (ok) exp_wb_q.push_back(res);
    else if (m_fail < 255) m_fail++;
  endtask

  // monitor: every pulse and write-back is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (auth_done && auth_fail) check("pulse_exclusive", 32'(2'b11), 32'(2'b01));
      if (auth_done || auth_fail) begin
        n_pulse_seen++;
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pulse_unexpected: got done=%0b fail=%0b, required no pulse", auth_done, auth_fail);
        end else begin
          e_res = exp_res_q.pop_front();
          check("pulse_kind", 32'(auth_done), 32'(e_res));
        end
      end
      if (wb_valid) begin
        n_wb_seen++;
        if (exp_wb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_data=%0h, required no wb_valid", wb_data);
        end else begin
          e_wb = exp_wb_q.pop_front();
          check("wb_data", 32'(wb_data), 32'(e_wb));
        end
      end
    end
  end

  // driver tasks (enter and leave on a negedge)
  task automatic rnd_step();
    if (rnd_hold) wb_hold = ($urandom_range(0, 3) == 0);
  endtask

  task automatic cfg_write(input logic [2:0] idx, input bit v, input logic [6:0] id, input logic [7:0] key);
    cfg_we = 1'b1; cfg_idx = idx; cfg_vld = v; cfg_id = id; cfg_key = key;
    @(negedge clk);
    cfg_we = 1'b0;
    m_vld[idx] = v; m_id[idx] = id; m_key[idx] = key;
  endtask

  task automatic wait_idle();
    int j;
    j = 0;
    while (busy && j < 300) begin
      @(negedge clk);
      rnd_step();
      j++;
    end
    if (busy) check("idle_wait_timeout", 32'(busy), 32'(0));
  endtask

  task automatic do_req(input logic [15:0] fr, input bit chk_lat, input bit exp_stall);
    bit ok;
    bit got;
    int j;
    int budget;
    expect_req(fr, ok);
    wait_idle();
    start = 1'b1;
    frame = fr;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (pw_en) begin
      cfg_we = 1'b1; cfg_idx = pw_idx; cfg_vld = 1'b1; cfg_id = pw_id; cfg_key = pw_key;
    end
    got = 1'b0;
    budget = exp_stall ? 12 : 300;
    for (j = 0; j < budget; j++) begin
      if (j > 0) begin
        @(negedge clk);
        rnd_step();
        if (j == 1 && pw_en) begin
          cfg_we = 1'b0;
          m_vld[pw_idx] = 1'b1; m_id[pw_idx] = pw_id; m_key[pw_idx] = pw_key;
          pw_en = 1'b0;
        end
      end
      if (auth_done || auth_fail) begin
        got = 1'b1;
        break;
      end
    end
    if (exp_stall) begin
      check("stall_no_pulse", 32'(got), 32'(0));
      check("stall_busy", 32'(busy), 32'(1));
      check("stall_state", 32'(dbg_state), 32'(S_PROC));
    end else begin
      check("req_pulse_seen", 32'(got), 32'(1));
      if (chk_lat && got) check("req_latency", 32'(j + 1), ok ? 32'(PROC_LAT + 2) : 32'(2));
    end
  endtask

  task automatic check_fail_cnt();
    @(negedge clk);
    check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (exp_res_q.size() != 0 || exp_wb_q.size() != 0); k++) @(negedge clk);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (wb_valid || auth_done || auth_fail) seen++;
    end
    check(name, 32'(seen), 32'(0));
  endtask

  // main sequence
  initial begin
    bit ok;
    int first;
    int second;
    int wb0;
    logic [15:0] fr;

    n_checks = 0; n_fail = 0; n_wb_seen = 0; n_pulse_seen = 0;
    rnd_hold = 1'b0; pw_en = 1'b0;
    pw_idx = '0; pw_id = '0; pw_key = '0;
    rst_n = 1'b0; start = 1'b0; frame = '0; wb_hold = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_vld = 1'b0; cfg_id = '0; cfg_key = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(auth_done), 32'(0));
    check("rst_fail", 32'(auth_fail), 32'(0));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_wb_data", 32'(wb_data), 32'(0));
    check("rst_fail_cnt", 32'(fail_cnt), 32'(0));
    check("rst_fifo_cnt", 32'(dbg_fifo_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // basic accept, result one cycle after done
    cfg_write(3'd0, 1'b1, 7'h15, 8'hFF);
    do_req(16'h1534, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_wb_valid", 32'(wb_valid), 32'(1));
    check("t1_wb_data", 32'(wb_data), 32'(8'hCB));

    // absent ID and already-processed frame both fail with nothing queued
    do_req(16'h1634, 1'b1, 1'b0);
    check_fail_cnt();
    watch_quiet("t2_no_wb", 4);
    do_req(16'h9534, 1'b1, 1'b0);
    check_fail_cnt();
    watch_quiet("t3_no_wb", 4);
    check("t3_fifo_empty", 32'(dbg_fifo_cnt), 32'(0));

    // table write on the lookup edge is not visible to that lookup
    pw_en = 1'b1; pw_idx = 3'd1; pw_id = 7'h20; pw_key = 8'h5A;
    do_req(16'h2011, 1'b1, 1'b0);
    do_req(16'h2011, 1'b1, 1'b0);
    drain();

    // back-pressure: four results fill the FIFO, the fifth stalls until release
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) do_req(16'h1500 | 16'(i * 37), 1'b1, 1'b0);
    @(negedge clk);
    check("t4_fifo_full", 32'(dbg_fifo_cnt), 32'(FIFO_DEPTH));
    do_req(16'h15AA, 1'b0, 1'b1);
    wb0 = n_wb_seen;
    wb_hold = 1'b0;
    drain();
    check("t4_wb_count", 32'(n_wb_seen - wb0), 32'(5));
    check("t4_res_q_empty", 32'(exp_res_q.size()), 32'(0));

    // start held high: second accept only after the guard window
    expect_req(16'h1577, ok);
    expect_req(16'h1577, ok);
    wait_idle();
    start = 1'b1;
    frame = 16'h1577;
    first = -1;
    second = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (auth_done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          break;
        end
      end
    end
    start = 1'b0;
    check("t5_done_gap", 32'(second - first), 32'(PROC_LAT + GUARD_CYC + 3));
    drain();

    // randomized traffic with random back-pressure
    for (int i = 0; i < N_IDS; i++)
      cfg_write(3'(i), ($urandom_range(0, 3) != 0), 7'(16 + $urandom_range(0, 5)), 8'($urandom));
    rnd_hold = 1'b1;
    for (int n = 0; n < 48; n++) begin
      fr = {($urandom_range(0, 7) == 0), 7'(16 + $urandom_range(0, 5)), 8'($urandom)};
      do_req(fr, 1'b0, 1'b0);
      if (n % 8 == 7)
        cfg_write(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  7'(16 + $urandom_range(0, 5)), 8'($urandom));
    end
    rnd_hold = 1'b0;
    wb_hold = 1'b0;
    drain();
    check("rnd_res_q_empty", 32'(exp_res_q.size()), 32'(0));
    check("rnd_wb_q_empty", 32'(exp_wb_q.size()), 32'(0));
    check_fail_cnt();

    // reset in the middle of processing
    cfg_write(3'd0, 1'b1, 7'h15, 8'hFF);
    wb_hold = 1'b1;
    do_req(16'h1534, 1'b1, 1'b0);
    wait_idle();
    start = 1'b1;
    frame = 16'h1534;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t6_in_proc", 32'(dbg_state), 32'(S_PROC));
    rst_n = 1'b0;
    exp_res_q.delete();
    exp_wb_q.delete();
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_fifo_cnt", 32'(dbg_fifo_cnt), 32'(0));
    check("t6_pulses", 32'({auth_done, auth_fail, wb_valid}), 32'(0));
    check("t6_fail_cnt", 32'(fail_cnt), 32'(0));
    rst_n = 1'b1;
    model_clear();
    wb_hold = 1'b0;
    watch_quiet("t6_quiet", 8);

    // fail counter saturation (table cleared by reset, so every request fails)
    for (int i = 0; i < 257; i++) begin
      do_req({1'b0, 7'($urandom), 8'($urandom)}, (i == 0), 1'b0);
      if (i == 100) check_fail_cnt();
    end
    check_fail_cnt();
    check("sat_value", 32'(fail_cnt), 32'(255));
    drain();
    check("end_res_q_empty", 32'(exp_res_q.size()), 32'(0));
    check("end_wb_q_empty", 32'(exp_wb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
